dphy_byte_align: RTL and testbench
==================================

Name: dphy_byte_align

Overview:
- Consumes the raw 8-bit HS word stream from the lane deserializer, together with the HS window flag from the settle-ignore stage.
- Hunts for the D-PHY leader/sync byte at any of 8 bit offsets and locks to that offset.
- Emits byte-aligned payload bytes to the lane merger / packet parser, with sync-found and alignment-error indications.
- One instance per data lane.

Parameters:
- SYNC_BYTE, 8'hB8, sync pattern (LSB-first leader 0001_1101).
- SYNC_TIMEOUT, 32, max valid bytes searched after the window opens before declaring an alignment error.

Ports:
- clk_i  input  1  byte clock (deserializer parallel clock)
- srst_i  input  1  reset, asynchronous, active-high
- hs_data_i  input  8  raw deserialized lane word, bit 0 earliest on the wire
- hs_data_valid_i  input  1  HS window open (from settle-ignore stage); level
- byte_o  output  8  aligned payload byte
- byte_valid_o  output  1  byte_o qualifier
- sync_o  output  1  one-cycle pulse when the sync byte is detected
- bit_offset_o  output  3  locked offset, held until next lock
- align_err_o  output  1  level; sync not found within SYNC_TIMEOUT

Behaviour:
- Clock and reset: one clock, clk_i. Reset srst_i is asynchronous, active-high.
- Reset values: all outputs 0; state IDLE_S; prev_byte 0; counters 0.
- Search window: prev_byte registers hs_data_i on every cycle where hs_data_valid_i=1. window[15:0] = {hs_data_i, prev_byte}. Candidate k (0..7) = window[k+7:k].
- States:
  - IDLE_S: hs_data_valid_i=1 -> FIRST_S.
  - FIRST_S: loads prev_byte only, no search, because prev_byte is stale. Next cycle -> SEARCH_S.
  - SEARCH_S: each valid cycle, test all 8 candidates. On one or more matches, the lowest k wins. Then:
    - bit_offset_o <= k.
    - sync_o pulses in the following cycle.
    - -> ALIGNED_S.
    - The sync byte itself is never output.
    - The timeout counter increments per searched byte. When it reaches SYNC_TIMEOUT with no match -> ERR_S.
  - ALIGNED_S: every cycle, byte_o <= window[off+7:off] and byte_valid_o <= 1. Output is registered, so latency is 1 clock from the input byte that completes the payload byte. No re-search while aligned.
  - ERR_S: align_err_o=1, byte_valid_o=0. Held until the window closes.
- hs_data_valid_i=0 in any state:
  - next state IDLE_S;
  - byte_valid_o=0 in the next cycle;
  - align_err_o cleared in the next cycle;
  - timeout counter cleared;
  - bit_offset_o retained.
- Bytes already straddling the window close are dropped. No flush of a partial byte.
- Window reopened (IDLE_S -> FIRST_S) always restarts the search. The prior offset is not reused.
- Match on the very first searched cycle with k=0 means prev_byte == SYNC_BYTE. This is legal.
- Timeout counter width is $clog2(SYNC_TIMEOUT+1) and saturates. Comparison is equality.
- Reset asserted mid-packet: immediate return to reset values, with no glitch pulse on sync_o.
- sync_o and byte_valid_o are never high in the same cycle. The first payload byte appears no earlier than 1 cycle after sync_o.

Decomposition:
- csi2_pkg (shared):
  - constant DPHY_SYNC_BYTE = 8'hB8;
  - typedef logic [7:0] lane_byte_t;
  - the align state enum (IDLE_S, FIRST_S, SEARCH_S, ALIGNED_S, ERR_S), encoded logic [2:0].
- Optional sub-module dphy_sync_search:
  - purely combinational 16-bit window -> {match, offset[2:0]} with lowest-offset priority;
  - reused later by the multi-lane deskew block.
- All sequential logic stays in dphy_byte_align.

Test Plan:
- Offset 0: valid rises; bytes 0x00, 0xB8, 0x11, 0x22, 0x33 -> sync_o pulse, bit_offset_o=0, byte_o sequence 0x11, 0x22, 0x33, each with byte_valid_o=1, 1 clock after the input.
- Offset 3: serialize 0x00 + 0xB8 + 0xA5 + 0x5A shifted by 3 bits (LSB-first) into words -> bit_offset_o=3, outputs 0xA5, 0x5A, sync byte not emitted.
- Sweep k=0..7 with random payload (fixed seed) -> bit_offset_o=k and the payload matches the scoreboard exactly for every k.
- Timeout: 40 bytes of 0x55 with no sync -> align_err_o rises after the 32nd searched byte and byte_valid_o stays 0. Dropping hs_data_valid_i clears align_err_o the next cycle.
- Window close/reopen: aligned at k=5, valid drops for 3 cycles, then reopens with sync at k=2 -> byte_valid_o low during the gap, re-lock with bit_offset_o=2, no stale bytes output.
- Async reset mid-payload: srst_i pulsed between clock edges while ALIGNED_S -> all outputs 0 immediately, state IDLE_S, clean re-lock on the next window.

Source files
------------

// File: rtl/csi2_pkg.sv
// Shared CSI-2 / D-PHY receive definitions: sync byte, lane byte type and
// the byte-alignment state encoding.
package csi2_pkg;

  // D-PHY leader/sync byte (LSB-first on the wire: 0001_1101)
  localparam logic [7:0] DPHY_SYNC_BYTE = 8'hB8;

  typedef logic [7:0] lane_byte_t;

  typedef enum logic [2:0] {
    IDLE_S    = 3'd0,
    FIRST_S   = 3'd1,
    SEARCH_S  = 3'd2,
    ALIGNED_S = 3'd3,
    ERR_S     = 3'd4
  } align_state_t;

endpackage

// File: rtl/dphy_sync_search.sv
// Combinational sync-byte finder over a 16-bit window of two lane words.
// Candidate k is window[k+7:k]; when several offsets match, the lowest wins.
module dphy_sync_search
  import csi2_pkg::*;
#(
  parameter lane_byte_t SYNC_BYTE = DPHY_SYNC_BYTE
) (
  input  logic [15:0] window_i,
  output logic        match_o,
  output logic [2:0]  offset_o
);

  logic [7:0] w_hit;

  for (genvar gi = 0; gi < 8; gi++) begin : g_cand
    assign w_hit[gi] = (window_i[gi +: 8] == SYNC_BYTE);
  end

  assign match_o = |w_hit;

  // Priority encode: scan from the top so the lowest matching offset is left
  always_comb begin
    offset_o = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_hit[i]) offset_o = i[2:0];
    end
  end

endmodule

// File: rtl/dphy_byte_align.sv
// Per-lane D-PHY byte aligner: hunts for the sync byte at any of 8 bit
// offsets inside the HS window, locks to it and then emits aligned payload
// bytes. Raises a level error if no sync appears within SYNC_TIMEOUT bytes.
module dphy_byte_align
  import csi2_pkg::*;
#(
  parameter lane_byte_t SYNC_BYTE    = DPHY_SYNC_BYTE,
  parameter int         SYNC_TIMEOUT = 32
) (
  input  logic       clk_i,
  input  logic       srst_i,
  input  logic [7:0] hs_data_i,
  input  logic       hs_data_valid_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       sync_o,
  output logic [2:0] bit_offset_o,
  output logic       align_err_o
);

  localparam int CNT_W = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(SYNC_TIMEOUT);

  align_state_t     r_state;
  lane_byte_t       r_prev_byte;
  logic [CNT_W-1:0] r_timeout_cnt;
  lane_byte_t       r_byte;
  logic             r_byte_valid;
  logic             r_sync;
  logic [2:0]       r_offset;
  logic             r_align_err;

  logic [15:0]      w_window;
  logic             w_match;
  logic [2:0]       w_match_off;
  lane_byte_t       w_aligned_byte;
  logic [CNT_W-1:0] w_cnt_inc;

  // Newest word on top: bit 0 of prev_byte is the earliest bit on the wire
  assign w_window       = {hs_data_i, r_prev_byte};
  assign w_aligned_byte = w_window[r_offset +: 8];
  // Saturating increment so the counter can never wrap past the limit
  assign w_cnt_inc      = (r_timeout_cnt == CNT_LIMIT) ? r_timeout_cnt
                                                       : r_timeout_cnt + 1'b1;

  dphy_sync_search #(
    .SYNC_BYTE (SYNC_BYTE)
  ) u_search (
    .window_i (w_window),
    .match_o  (w_match),
    .offset_o (w_match_off)
  );

  // Alignment FSM with registered outputs; window close overrides every state
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_state       <= IDLE_S;
      r_prev_byte   <= '0;
      r_timeout_cnt <= '0;
      r_byte        <= '0;
      r_byte_valid  <= 1'b0;
      r_sync        <= 1'b0;
      r_offset      <= 3'd0;
      r_align_err   <= 1'b0;
    end else begin
      r_sync <= 1'b0;
      if (hs_data_valid_i) r_prev_byte <= hs_data_i;

      if (!hs_data_valid_i) begin
        // Partial bytes straddling the close are simply dropped
        r_state       <= IDLE_S;
        r_byte_valid  <= 1'b0;
        r_align_err   <= 1'b0;
        r_timeout_cnt <= '0;
      end else begin
        case (r_state)
          IDLE_S: begin
            r_state       <= FIRST_S;
            r_byte_valid  <= 1'b0;
            r_timeout_cnt <= '0;
          end
          // prev_byte is stale from an earlier window, so only refill it here
          FIRST_S: r_state <= SEARCH_S;
          SEARCH_S: begin
            if (w_match) begin
              r_offset <= w_match_off;
              r_sync   <= 1'b1;
              r_state  <= ALIGNED_S;
            end else begin
              r_timeout_cnt <= w_cnt_inc;
              if (w_cnt_inc == CNT_LIMIT) begin
                r_state     <= ERR_S;
                r_align_err <= 1'b1;
              end
            end
          end
          ALIGNED_S: begin
            r_byte       <= w_aligned_byte;
            r_byte_valid <= 1'b1;
          end
          ERR_S: begin
            r_align_err  <= 1'b1;
            r_byte_valid <= 1'b0;
          end
          default: r_state <= IDLE_S;
        endcase
      end
    end
  end

  assign byte_o       = r_byte;
  assign byte_valid_o = r_byte_valid;
  assign sync_o       = r_sync;
  assign bit_offset_o = r_offset;
  assign align_err_o  = r_align_err;

endmodule

// File: tb/tb_dphy_byte_align.sv
// Directed/randomized bench for dphy_byte_align. The reference model treats
// each HS window as a flat LSB-first bit stream, locates the first sync
// position arithmetically and predicts every output cycle by cycle.
module tb_dphy_byte_align;

  localparam int TIMEOUT = 32;

  logic       clk_i = 1'b0;
  logic       srst_i;
  logic [7:0] hs_data_i;
  logic       hs_data_valid_i;
  logic [7:0] byte_o;
  logic       byte_valid_o;
  logic       sync_o;
  logic [2:0] bit_offset_o;
  logic       align_err_o;

  always #5 clk_i = ~clk_i;

  dphy_byte_align #(
    .SYNC_BYTE    (8'hB8),
    .SYNC_TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i           (clk_i),
    .srst_i          (srst_i),
    .hs_data_i       (hs_data_i),
    .hs_data_valid_i (hs_data_valid_i),
    .byte_o          (byte_o),
    .byte_valid_o    (byte_valid_o),
    .sync_o          (sync_o),
    .bit_offset_o    (bit_offset_o),
    .align_err_o     (align_err_o)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] win [0:63];   // win[0] is the IDLE-cycle word, stream starts at win[1]
  int         win_len;      // index of last word driven in the window
  logic [7:0] pl [0:15];
  int         np;
  logic [2:0] cur_off = 3'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Bit pos of the window's stream (stream bit 0 = win[1] bit 0)
  function automatic logic sbit(input int pos);
    logic [7:0] w;
    w = win[1 + pos / 8];
    return w[pos % 8];
  endfunction

  function automatic logic [7:0] sbyte(input int pos);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = sbit(pos + i);
    return b;
  endfunction

  // k zero bits, sync byte, payload pl[0..np-1], zero pad, one random trailer word
  task automatic build(input int k);
    logic       bits [0:511];
    logic [7:0] sync_b;
    logic [7:0] wd;
    int         pos;
    int         nw;
    sync_b = 8'hB8;
    pos = 0;
    for (int i = 0; i < k; i++) begin bits[pos] = 1'b0; pos++; end
    for (int i = 0; i < 8; i++) begin bits[pos] = sync_b[i]; pos++; end
    for (int j = 0; j < np; j++) begin
      wd = pl[j];
      for (int i = 0; i < 8; i++) begin bits[pos] = wd[i]; pos++; end
    end
    while (pos % 8 != 0) begin bits[pos] = 1'b0; pos++; end
    nw = pos / 8;
    win[0] = 8'h00;
    for (int w = 0; w < nw; w++) begin
      for (int i = 0; i < 8; i++) wd[i] = bits[8 * w + i];
      win[w + 1] = wd;
    end
    win[nw + 1] = 8'($urandom);
    win_len = nw + 1;
  endtask

  task automatic rand_payload(input int n);
    np = n;
    for (int j = 0; j < n; j++) pl[j] = 8'($urandom);
  endtask

  // Drive win[0..min(win_len,stop_t)] with valid high, checking each cycle
  task automatic run_window(input string name, input int stop_t);
    bit         found;
    int         mn;
    int         mk;
    logic       exp_sync;
    logic       exp_bv;
    logic       exp_err;
    found = 0; mn = 0; mk = 0;
    // Searched cycle n covers stream positions 8(n-2)..8(n-2)+7
    for (int n = 2; n <= win_len && n <= TIMEOUT + 1 && !found; n++)
      for (int kk = 0; kk < 8 && !found; kk++)
        if (sbyte(8 * (n - 2) + kk) == 8'hB8) begin found = 1; mn = n; mk = kk; end
    for (int t = 0; t <= win_len && t <= stop_t; t++) begin
      hs_data_i       = win[t];
      hs_data_valid_i = 1'b1;
      @(posedge clk_i); #1;
      exp_sync = found && (t == mn);
      exp_bv   = found && (t > mn);
      exp_err  = !found && (t >= TIMEOUT + 1);
      if (found && t == mn) cur_off = mk[2:0];
      check({name, "_sync"}, sync_o, exp_sync);
      check({name, "_bvalid"}, byte_valid_o, exp_bv);
      check({name, "_err"}, align_err_o, exp_err);
      check({name, "_off"}, bit_offset_o, cur_off);
      if (exp_bv) check({name, "_byte"}, byte_o, sbyte(8 * (t - 2) + mk));
      $display("[%0t] %s t=%0d in=%02h out=%02h bv=%0b sync=%0b off=%0d err=%0b",
               $time, name, t, win[t], byte_o, byte_valid_o, sync_o, bit_offset_o, align_err_o);
    end
  endtask

  task automatic close_gap(input string name, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      hs_data_valid_i = 1'b0;
      hs_data_i       = 8'($urandom);
      @(posedge clk_i); #1;
      check({name, "_gap_bvalid"}, byte_valid_o, 1'b0);
      check({name, "_gap_sync"}, sync_o, 1'b0);
      check({name, "_gap_err"}, align_err_o, 1'b0);
      check({name, "_gap_off"}, bit_offset_o, cur_off);
      $display("[%0t] %s gap %0d bv=%0b err=%0b off=%0d",
               $time, name, c, byte_valid_o, align_err_o, bit_offset_o);
    end
  endtask

  initial begin
    void'($urandom(32'd20240611));
    srst_i = 1'b1; hs_data_valid_i = 1'b0; hs_data_i = 8'h00;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_byte", byte_o, 8'h00);
    check("rst_bvalid", byte_valid_o, 1'b0);
    check("rst_sync", sync_o, 1'b0);
    check("rst_off", bit_offset_o, 3'd0);
    check("rst_err", align_err_o, 1'b0);
    srst_i = 1'b0;
    close_gap("init", 2);

    // Offset 0: 00, B8, 11, 22, 33 (+trailer)
    np = 3; pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    build(0);
    run_window("off0", 99);
    close_gap("off0", 1);

    // Offset 3: A5, 5A after a 3-bit shifted sync
    np = 2; pl[0] = 8'hA5; pl[1] = 8'h5A;
    build(3);
    run_window("off3", 99);
    close_gap("off3", 1);

    // Sweep every offset with random payload
    for (int k = 0; k < 8; k++) begin
      rand_payload(4);
      build(k);
      run_window($sformatf("sweep%0d", k), 99);
      close_gap($sformatf("sweep%0d", k), 1);
    end

    // Timeout: 0x55 never contains the sync pattern at any offset
    for (int i = 0; i <= 40; i++) win[i] = 8'h55;
    win_len = 40;
    run_window("tmo", 99);
    close_gap("tmo", 1);

    // Close for 3 cycles while aligned at 5, reopen with sync at 2
    rand_payload(6);
    build(5);
    run_window("reopen_a", 99);
    close_gap("reopen", 3);
    rand_payload(5);
    build(2);
    run_window("reopen_b", 99);
    close_gap("reopen_b", 1);

    // Asynchronous reset between edges while aligned
    rand_payload(8);
    build(4);
    run_window("arst", 6);
    #2 srst_i = 1'b1;
    #1;
    check("arst_byte", byte_o, 8'h00);
    check("arst_bvalid", byte_valid_o, 1'b0);
    check("arst_sync", sync_o, 1'b0);
    check("arst_off", bit_offset_o, 3'd0);
    check("arst_err", align_err_o, 1'b0);
    check("arst_state", 32'(dut.r_state), 32'd0);
    $display("[%0t] arst applied out=%02h bv=%0b off=%0d", $time, byte_o, byte_valid_o, bit_offset_o);
    #1 srst_i = 1'b0;
    hs_data_valid_i = 1'b0;
    cur_off = 3'd0;
    close_gap("arst", 1);
    rand_payload(5);
    build(6);
    run_window("relock", 99);
    close_gap("relock", 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
